// File: rtl/conv_scan_counter_pkg.sv
// Shared types and width helpers for the convolution coordinate scanner.
package conv_scan_counter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // The extra bit keeps the input coordinate signed.
  function automatic int unsigned calc_xw(input int unsigned in_w, input int unsigned k);
    return clog2_min1(in_w + k) + 1;
  endfunction

endpackage

// File: rtl/conv_scan_counter_if.sv
// Control and coordinate bundle between the layer controller and the scanner.
interface conv_scan_counter_if
  import conv_scan_counter_pkg::*;
#(
  parameter int unsigned OUT_W = 30,
  parameter int unsigned OUT_H = 30,
  parameter int unsigned IN_W  = 30,
  parameter int unsigned CH    = 16,
  parameter int unsigned K     = 3
);
  localparam int unsigned XCW = clog2_min1(OUT_W);
  localparam int unsigned YCW = clog2_min1(OUT_H);
  localparam int unsigned CCW = clog2_min1(CH);
  localparam int unsigned KW  = clog2_min1(K);
  localparam int unsigned XW  = calc_xw(IN_W, K);

  logic                  start;
  logic                  stall;
  logic                  abort;
  logic                  busy;
  logic                  valid;
  logic [XCW-1:0]        x;
  logic [YCW-1:0]        y;
  logic [CCW-1:0]        ch;
  logic [KW-1:0]         kx;
  logic [KW-1:0]         ky;
  logic signed [XW-1:0]  ix;
  logic signed [XW-1:0]  iy;
  logic                  pad;
  logic                  last_term;
  logic                  done;

  modport master (
    output start, stall, abort,
    input  busy, valid, x, y, ch, kx, ky, ix, iy, pad, last_term, done
  );

  modport slave (
    input  start, stall, abort,
    output busy, valid, x, y, ch, kx, ky, ix, iy, pad, last_term, done
  );

endinterface

// File: rtl/conv_wrap_counter.sv
// Single wrapping counter stage; wrap feeds the inc of the next stage.
module conv_wrap_counter #(
  parameter int unsigned MAX   = 0,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX);

  logic [WIDTH-1:0] value_q, value_d;

  assign wrap  = inc & (value_q == MaxV);
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = wrap ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/conv_scan_counter.sv
// Walks every (y, x, ch, ky, kx) term of a conv layer and derives padded input coordinates.
module conv_scan_counter
  import conv_scan_counter_pkg::*;
#(
  parameter int unsigned OUT_W  = 30,
  parameter int unsigned OUT_H  = 30,
  parameter int unsigned IN_W   = 30,
  parameter int unsigned IN_H   = 30,
  parameter int unsigned CH     = 16,
  parameter int unsigned K      = 3,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned PAD    = 1
) (
  input  logic                clk,
  input  logic                rst,
  conv_scan_counter_if.slave  bus
);
  localparam int unsigned XCW = clog2_min1(OUT_W);
  localparam int unsigned YCW = clog2_min1(OUT_H);
  localparam int unsigned CCW = clog2_min1(CH);
  localparam int unsigned KW  = clog2_min1(K);
  localparam int unsigned XW  = calc_xw(IN_W, K);

  localparam logic [XW-1:0]  StrideV = XW'(STRIDE);
  localparam logic [XW-1:0]  PadV    = XW'(PAD);
  localparam logic [XW-1:0]  InWV    = XW'(IN_W);
  localparam logic [XW-1:0]  InHV    = XW'(IN_H);
  localparam logic [KW-1:0]  KLast   = KW'(K - 1);
  localparam logic [CCW-1:0] ChLast  = CCW'(CH - 1);

  state_e state_q, state_d;

  logic [4:0]     inc, wrap;
  logic           clr;
  logic           scan;
  logic [KW-1:0]  kx_cnt, ky_cnt;
  logic [CCW-1:0] ch_cnt;
  logic [XCW-1:0] x_cnt;
  logic [YCW-1:0] y_cnt;
  logic [XW-1:0]  ix_raw, iy_raw;
  logic           ix_out, iy_out;

  assign scan   = (state_q == StScan);
  assign inc[0] = scan & ~bus.stall & ~bus.abort;
  assign inc[4:1] = wrap[3:0];
  assign clr    = scan & bus.abort;

  conv_wrap_counter #(.MAX(K - 1), .WIDTH(KW)) u_kx (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc[0]), .value(kx_cnt), .wrap(wrap[0])
  );
  conv_wrap_counter #(.MAX(K - 1), .WIDTH(KW)) u_ky (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc[1]), .value(ky_cnt), .wrap(wrap[1])
  );
  conv_wrap_counter #(.MAX(CH - 1), .WIDTH(CCW)) u_ch (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc[2]), .value(ch_cnt), .wrap(wrap[2])
  );
  conv_wrap_counter #(.MAX(OUT_W - 1), .WIDTH(XCW)) u_x (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc[3]), .value(x_cnt), .wrap(wrap[3])
  );
  conv_wrap_counter #(.MAX(OUT_H - 1), .WIDTH(YCW)) u_y (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc[4]), .value(y_cnt), .wrap(wrap[4])
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start && !bus.abort) state_d = StScan;
      StScan: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (wrap[4]) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Two's-complement wrap in XW bits yields the signed result directly.
  assign ix_raw = XW'(x_cnt) * StrideV + XW'(kx_cnt) - PadV;
  assign iy_raw = XW'(y_cnt) * StrideV + XW'(ky_cnt) - PadV;

  assign ix_out = ix_raw[XW-1] | (ix_raw >= InWV);
  assign iy_out = iy_raw[XW-1] | (iy_raw >= InHV);

  assign bus.busy      = scan;
  assign bus.valid     = scan;
  assign bus.done      = (state_q == StDone);
  assign bus.x         = x_cnt;
  assign bus.y         = y_cnt;
  assign bus.ch        = ch_cnt;
  assign bus.kx        = kx_cnt;
  assign bus.ky        = ky_cnt;
  assign bus.ix        = $signed(ix_raw);
  assign bus.iy        = $signed(iy_raw);
  assign bus.pad       = scan & (ix_out | iy_out);
  assign bus.last_term = scan & (kx_cnt == KLast) & (ky_cnt == KLast) & (ch_cnt == ChLast);

endmodule

// File: tb/tb_conv_scan_counter.sv
// Bench for conv_scan_counter: two configurations checked against a nested-loop tuple model.
module tb_conv_scan_counter;

  typedef struct {
    int x;
    int y;
    int ch;
    int kx;
    int ky;
  } tup_t;

  typedef struct {
    int ow;
    int oh;
    int iw;
    int ih;
    int ch;
    int k;
    int s;
    int p;
  } cfg_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  tup_t exp_q[$];
  tup_t zt;
  cfg_t ca, cb;

  conv_scan_counter_if #(.OUT_W(4), .OUT_H(4), .IN_W(4), .CH(2), .K(3)) ia ();
  conv_scan_counter_if #(.OUT_W(4), .OUT_H(4), .IN_W(9), .CH(1), .K(3)) ib ();

  conv_scan_counter #(
    .OUT_W(4), .OUT_H(4), .IN_W(4), .IN_H(4), .CH(2), .K(3), .STRIDE(1), .PAD(1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave)
  );

  conv_scan_counter #(
    .OUT_W(4), .OUT_H(4), .IN_W(9), .IN_H(9), .CH(1), .K(3), .STRIDE(2), .PAD(0)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave)
  );

  // Scan order straight from the loop nest: y outermost, kx innermost.
  function automatic void build(input cfg_t c);
    tup_t t;
    exp_q.delete();
    for (int y = 0; y < c.oh; y++)
      for (int x = 0; x < c.ow; x++)
        for (int ch = 0; ch < c.ch; ch++)
          for (int ky = 0; ky < c.k; ky++)
            for (int kx = 0; kx < c.k; kx++) begin
              t.x = x; t.y = y; t.ch = ch; t.kx = kx; t.ky = ky;
              exp_q.push_back(t);
            end
  endfunction

  function automatic string exp_str(input bit v, input bit d, input tup_t t, input cfg_t c);
    int ix = t.x * c.s + t.kx - c.p;
    int iy = t.y * c.s + t.ky - c.p;
    bit p  = v && (ix < 0 || ix >= c.iw || iy < 0 || iy >= c.ih);
    bit l  = v && t.kx == c.k - 1 && t.ky == c.k - 1 && t.ch == c.ch - 1;
    return $sformatf("v%0d b%0d d%0d x%0d y%0d c%0d kx%0d ky%0d ix%0d iy%0d p%0d l%0d",
                     v, v, d, t.x, t.y, t.ch, t.kx, t.ky, ix, iy, p, l);
  endfunction

  function automatic string fmt_a();
    return $sformatf("v%0d b%0d d%0d x%0d y%0d c%0d kx%0d ky%0d ix%0d iy%0d p%0d l%0d",
                     ia.valid, ia.busy, ia.done, ia.x, ia.y, ia.ch, ia.kx, ia.ky,
                     ia.ix, ia.iy, ia.pad, ia.last_term);
  endfunction

  function automatic string fmt_b();
    return $sformatf("v%0d b%0d d%0d x%0d y%0d c%0d kx%0d ky%0d ix%0d iy%0d p%0d l%0d",
                     ib.valid, ib.busy, ib.done, ib.x, ib.y, ib.ch, ib.kx, ib.ky,
                     ib.ix, ib.iy, ib.pad, ib.last_term);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    ia.start = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (fmt_a() != exp_str(0, 0, zt, ca)) begin
      n_bad++; $display("FAIL reset_a: got %s want %s", fmt_a(), exp_str(0, 0, zt, ca));
    end
    n_cmp++;
    if (fmt_b() != exp_str(0, 0, zt, cb)) begin
      n_bad++; $display("FAIL reset_b: got %s want %s", fmt_b(), exp_str(0, 0, zt, cb));
    end
    // start together with abort must not launch; stall in IDLE is inert.
    rst = 1'b0; ia.stall = 1'b1; ia.abort = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (fmt_a() != exp_str(0, 0, zt, ca)) begin
      n_bad++; $display("FAIL idle_hold: got %s want %s", fmt_a(), exp_str(0, 0, zt, ca));
    end
    ia.start = 1'b0; ia.stall = 1'b0; ia.abort = 1'b0;
  endtask

  task automatic test_full_scan();
    int lt = 0;
    build(ca);
    ia.start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      ia.start = (i == 100 || i == 101);
      n_cmp++;
      if (fmt_a() != exp_str(1, 0, exp_q[i], ca)) begin
        n_bad++; $display("FAIL scan_tuple %0d: got %s want %s", i, fmt_a(),
                          exp_str(1, 0, exp_q[i], ca));
      end
      if (ia.last_term === 1'b1) lt++;
      @(negedge clk);
    end
    ia.start = 1'b0;
    n_cmp++;
    if (fmt_a() != exp_str(0, 1, zt, ca)) begin
      n_bad++; $display("FAIL done_pulse: got %s want %s", fmt_a(), exp_str(0, 1, zt, ca));
    end
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    n_cmp++;
    if (fmt_a() != exp_str(0, 0, zt, ca)) begin
      n_bad++; $display("FAIL start_on_done: got %s want %s", fmt_a(), exp_str(0, 0, zt, ca));
    end
    @(negedge clk);
    n_cmp++;
    if (fmt_a() != exp_str(0, 0, zt, ca)) begin
      n_bad++; $display("FAIL idle_after_done: got %s want %s", fmt_a(),
                        exp_str(0, 0, zt, ca));
    end
    n_cmp++;
    if (lt !== 16) begin
      n_bad++; $display("FAIL last_term_count: got %0d want 16", lt);
    end
  endtask

  task automatic test_stall_fixed();
    int idx = 0;
    int cyc = 0;
    int hold = 0;
    int target = -1;
    bit s;
    build(ca);
    foreach (exp_q[i])
      if (exp_q[i].kx == 1 && exp_q[i].ky == 0 && exp_q[i].ch == 1 &&
          exp_q[i].x == 2 && exp_q[i].y == 0 && target < 0) target = i;
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    while (idx < exp_q.size() && cyc < 2000) begin
      n_cmp++;
      if (fmt_a() != exp_str(1, 0, exp_q[idx], ca)) begin
        n_bad++; $display("FAIL stall_tuple %0d: got %s want %s", idx, fmt_a(),
                          exp_str(1, 0, exp_q[idx], ca));
      end
      s = (idx == target) && (hold < 5);
      if (s) hold++;
      ia.stall = s;
      @(negedge clk);
      cyc++;
      if (!s) idx++;
    end
    ia.stall = 1'b0;
    n_cmp++;
    if (cyc !== 293 || fmt_a() != exp_str(0, 1, zt, ca)) begin
      n_bad++; $display("FAIL stall_done: got cyc %0d %s want cyc 293 %s", cyc, fmt_a(),
                        exp_str(0, 1, zt, ca));
    end
    @(negedge clk);
  endtask

  task automatic test_random_stall();
    int idx = 0;
    int cyc = 0;
    int nst = 0;
    bit s;
    build(ca);
    repeat ($urandom_range(1, 4)) begin
      ia.stall = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ia.start = 1'b1;
    ia.stall = 1'b0;
    @(negedge clk);
    ia.start = 1'b0;
    while (idx < exp_q.size() && cyc < 3000) begin
      n_cmp++;
      if (fmt_a() != exp_str(1, 0, exp_q[idx], ca)) begin
        n_bad++; $display("FAIL rstall_tuple %0d: got %s want %s", idx, fmt_a(),
                          exp_str(1, 0, exp_q[idx], ca));
      end
      s = ($urandom_range(0, 3) == 0);
      if (s) nst++;
      ia.stall = s;
      @(negedge clk);
      cyc++;
      if (!s) idx++;
    end
    // Stall on the done cycle must not extend it.
    ia.stall = 1'b1;
    n_cmp++;
    if (cyc !== 288 + nst || fmt_a() != exp_str(0, 1, zt, ca)) begin
      n_bad++; $display("FAIL rstall_done: got cyc %0d %s want cyc %0d %s", cyc, fmt_a(),
                        288 + nst, exp_str(0, 1, zt, ca));
    end
    @(negedge clk);
    ia.stall = 1'b0;
    n_cmp++;
    if (fmt_a() != exp_str(0, 0, zt, ca)) begin
      n_bad++; $display("FAIL done_not_extended: got %s want %s", fmt_a(),
                        exp_str(0, 0, zt, ca));
    end
  endtask

  task automatic test_abort();
    bit saw = 1'b0;
    int stop;
    build(ca);
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    repeat (99) @(negedge clk);
    n_cmp++;
    if (fmt_a() != exp_str(1, 0, exp_q[99], ca)) begin
      n_bad++; $display("FAIL abort_pre: got %s want %s", fmt_a(), exp_str(1, 0, exp_q[99], ca));
    end
    ia.abort = 1'b1;
    ia.stall = 1'b1;
    @(negedge clk);
    ia.abort = 1'b0;
    ia.stall = 1'b0;
    n_cmp++;
    if (fmt_a() != exp_str(0, 0, zt, ca)) begin
      n_bad++; $display("FAIL abort_idle: got %s want %s", fmt_a(), exp_str(0, 0, zt, ca));
    end
    repeat (4) begin
      @(negedge clk);
      if (ia.done !== 1'b0 || ia.busy !== 1'b0) saw = 1'b1;
    end
    n_cmp++;
    if (saw) begin
      n_bad++; $display("FAIL abort_no_done: got done/busy activity want none");
    end
    repeat ($urandom_range(0, 5)) @(negedge clk);
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    stop = $urandom_range(5, 150);
    for (int i = 0; i < stop; i++) begin
      n_cmp++;
      if (fmt_a() != exp_str(1, 0, exp_q[i], ca)) begin
        n_bad++; $display("FAIL replay %0d: got %s want %s", i, fmt_a(),
                          exp_str(1, 0, exp_q[i], ca));
      end
      @(negedge clk);
    end
    ia.abort = 1'b1;
    @(negedge clk);
    ia.abort = 1'b0;
    n_cmp++;
    if (fmt_a() != exp_str(0, 0, zt, ca)) begin
      n_bad++; $display("FAIL abort_random: got %s want %s", fmt_a(), exp_str(0, 0, zt, ca));
    end
  endtask

  task automatic test_stride();
    bit pad_seen = 1'b0;
    int lix = 0;
    int liy = 0;
    build(cb);
    ib.start = 1'b1;
    @(negedge clk);
    ib.start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (fmt_b() != exp_str(1, 0, exp_q[i], cb)) begin
        n_bad++; $display("FAIL stride_tuple %0d: got %s want %s", i, fmt_b(),
                          exp_str(1, 0, exp_q[i], cb));
      end
      if (ib.pad !== 1'b0) pad_seen = 1'b1;
      lix = int'(ib.ix);
      liy = int'(ib.iy);
      @(negedge clk);
    end
    n_cmp++;
    if (pad_seen) begin
      n_bad++; $display("FAIL stride_pad: got pad asserted want never");
    end
    n_cmp++;
    if (lix !== 8 || liy !== 8) begin
      n_bad++; $display("FAIL stride_last: got ix %0d iy %0d want 8 8", lix, liy);
    end
    n_cmp++;
    if (fmt_b() != exp_str(0, 1, zt, cb)) begin
      n_bad++; $display("FAIL stride_done: got %s want %s", fmt_b(), exp_str(0, 1, zt, cb));
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bit saw = 1'b0;
    build(ca);
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    repeat (50) @(negedge clk);
    n_cmp++;
    if (fmt_a() != exp_str(1, 0, exp_q[50], ca)) begin
      n_bad++; $display("FAIL mid_pre: got %s want %s", fmt_a(), exp_str(1, 0, exp_q[50], ca));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (fmt_a() != exp_str(0, 0, zt, ca)) begin
      n_bad++; $display("FAIL mid_reset: got %s want %s", fmt_a(), exp_str(0, 0, zt, ca));
    end
    repeat (3) begin
      @(negedge clk);
      if (ia.done !== 1'b0 || ia.busy !== 1'b0) saw = 1'b1;
    end
    n_cmp++;
    if (saw) begin
      n_bad++; $display("FAIL mid_reset_no_done: got done/busy activity want none");
    end
  endtask

  initial begin
    ca = '{ow: 4, oh: 4, iw: 4, ih: 4, ch: 2, k: 3, s: 1, p: 1};
    cb = '{ow: 4, oh: 4, iw: 9, ih: 9, ch: 1, k: 3, s: 2, p: 0};
    zt = '{x: 0, y: 0, ch: 0, kx: 0, ky: 0};
    rst = 1'b1;
    ia.start = 1'b0; ia.stall = 1'b0; ia.abort = 1'b0;
    ib.start = 1'b0; ib.stall = 1'b0; ib.abort = 1'b0;
    test_reset();
    test_full_scan();
    test_stall_fixed();
    test_random_stall();
    test_abort();
    test_stride();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_scan_counter.md
# conv_scan_counter

Parametrised coordinate generator for the convolution layers. One start request walks every output pixel of a layer and, for each pixel, every (input channel, kernel row, kernel column) term, emitting one coordinate tuple per non-stalled cycle. It generalises the fixed 30-wide per-layer x/y counters: feature-map size, channel count, kernel size, stride and padding are parameters. Stall and abort inputs are included, plus the derived input-map coordinates with a padding flag. It sits between the layer controller and the weight/activation address generators.

## Interface
- OUT_W, 30, output feature-map width (x range 0..OUT_W-1)
- OUT_H, 30, output feature-map height
- IN_W, 30, input feature-map width (padding bound)
- IN_H, 30, input feature-map height
- CH, 16, input channels accumulated per output pixel
- K, 3, kernel size (K x K); K ≥ 1
- STRIDE, 1, spatial stride ≥ 1
- PAD, 1, zero-padding on each border, PAD < K

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  begin a scan; sampled only in IDLE
- stall  in  1  hold all counters and outputs
- abort  in  1  terminate scan, return to IDLE
- busy  out  1  scan in progress
- valid  out  1  current tuple is a live term
- x, y  out  clog2(OUT_W), clog2(OUT_H)  output pixel
- ch  out  clog2(CH)  input channel
- kx, ky  out  clog2(K) (min 1)  kernel column/row
- ix, iy  out  signed, XW = clog2(IN_W+K)+1  input coordinate
- pad  out  1  (ix,iy) lies outside the input map
- last_term  out  1  final term of the current output pixel
- done  out  1  one-cycle pulse after the last term

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: busy=0, valid=0, all counters 0. start=1 and abort=0 → SCAN.
- SCAN: busy=1, valid=1. Counter order, innermost first: kx, ky, ch, x, y.
- Each SCAN cycle with stall=0 advances kx. A counter wraps to 0 at its maximum and carries into the next counter.
- When the full tuple (K-1, K-1, CH-1, OUT_W-1, OUT_H-1) advances → DONE, with counters cleared.
- DONE: done=1, busy=0, valid=0 for exactly one cycle → IDLE.
- ix = x*STRIDE + kx − PAD and iy = y*STRIDE + ky − PAD, both signed.
- pad = (ix<0) | (ix≥IN_W) | (iy<0) | (iy≥IN_H). pad is forced 0 when valid=0.
- last_term = valid & (kx==K-1) & (ky==K-1) & (ch==CH-1).
- Priority: rst > abort > stall > advance.
- abort in SCAN → IDLE next cycle, counters cleared, no done pulse. abort in IDLE or DONE is ignored, but DONE still returns to IDLE.
- start while busy is ignored. start concurrent with done is ignored; a new start is required in IDLE.
- stall in IDLE/DONE has no effect; DONE is never extended.
- Degenerate parameters: a counter with maximum 0 (e.g. CH=1, K=1) is constant 0 and always carries.

## Timing
- Reset values: busy=0, valid=0, done=0, x=y=ch=kx=ky=0, last_term=0, pad=0. ix = iy = −PAD internally; not meaningful while valid=0.
- start sampled at edge n → first tuple (all 0) valid from edge n+1.
- The scan has N = K·K·CH·OUT_W·OUT_H non-stalled SCAN cycles.
- With no stalls, done is high for the cycle following the Nth valid cycle.
- Each stalled cycle delays done by one cycle.
- Counters are registered. ix, iy, pad and last_term are combinational from the counter registers (zero-cycle latency relative to the tuple).
- Reset asserted mid-scan: next cycle equals the reset state; no done pulse.

## Structure
- Shared layer package:
  - state enum (IDLE, SCAN, DONE)
  - width helper function (clog2 with minimum 1)
  - XW derivation
- Sub-module conv_wrap_counter, instantiated five times. Parameter MAX. Inputs: clk, rst, clr, inc. Outputs: value, wrap.
  - wrap = inc & (value==MAX).
  - Carry chain: inc of each stage = wrap of the previous stage. Stage 0 inc = SCAN & ~stall & ~abort.
- The FSM, the ix/iy arithmetic (widen to XW before subtracting PAD) and the pad compare live in the top module.

## Test plan
- Defaults off; OUT_W=OUT_H=IN_W=IN_H=4, CH=2, K=3, STRIDE=1, PAD=1, start pulse → 288 valid cycles, done at cycle 289, tuple sequence matches a nested-loop model. First tuple has ix=iy=−1 with pad=1.
- Same config, stall held 5 cycles at tuple (kx=1, ky=0, ch=1, x=2, y=0) → outputs frozen for those 5 cycles, done delayed by exactly 5 cycles.
- abort on the 100th valid cycle, with stall also high → IDLE next cycle, counters 0, no done pulse. A new start replays from (0,0,0,0,0).
- STRIDE=2, PAD=0, IN_W=IN_H=9, OUT_W=OUT_H=4, K=3, CH=1 → pad never asserts; last tuple has ix=iy=8.
- last_term check: asserts exactly 16 times in the 288-cycle scan, only on tuples with kx=ky=2 and ch=1.
- start asserted during SCAN and again on the done cycle → both ignored. rst pulsed at cycle 50 → all outputs at reset values next cycle.
